riscv151_core: RTL and testbench

- 3-stage pipelined RV32I processor core: IF / ID+EX / MEM+WB.
- Contains its own 32x32 register file, instruction memory and data memory.
- Top-level CPU block of the FPGA design; the serial pins are reserved for the board UART.
- Programs are preloaded into instruction memory. Verification peeks at the register-file array and the data-memory array hierarchically.

---
 rtl/riscv151_core.sv | 267 ++++++++++++++++++++++++++
 tb/tb_riscv151_core.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv151_core.sv
// riscv151_core: 3-stage RV32I core (IF / ID+EX / MEM+WB)
// with private register file, instruction and data memories.

package riscv151_pkg;
  typedef enum logic [1:0] {
    WB_ALU,
    WB_MEM,
    WB_PC4
  } wb_sel_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rd;
    wb_sel_e     wb_sel;
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [31:0] pc4;
  } ex_wb_t;
endpackage

module riscv151_core
  import riscv151_pkg::*;
#(
  parameter int unsigned CPU_CLOCK_FREQ  = 50_000_000,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH_WORDS = 16384
) (
  input  logic clk,
  input  logic rst,
  input  logic FPGA_SERIAL_RX,
  output logic FPGA_SERIAL_TX
);
  localparam int AW = $clog2(MEM_DEPTH_WORDS);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  logic [31:0] imem [MEM_DEPTH_WORDS];
  logic [31:0] dmem [MEM_DEPTH_WORDS];
  logic [31:0][31:0] rf;

  logic [31:0] pc;
  if_id_t      fd;
  ex_wb_t      xw;

  logic [31:0] inst;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;
  assign inst = fd.inst;
  assign opc  = inst[6:0];
  assign f3   = inst[14:12];
  assign rs1  = inst[19:15];
  assign rs2  = inst[24:20];
  assign rd   = inst[11:7];

  logic is_lui, is_aui, is_jal, is_jlr;
  logic is_br, is_ld, is_st, is_opi, is_op;
  assign is_lui = opc == OP_LUI;
  assign is_aui = opc == OP_AUI;
  assign is_jal = opc == OP_JAL;
  assign is_jlr = opc == OP_JLR && f3 == 3'b000;
  assign is_br  = opc == OP_BR;
  assign is_ld  = opc == OP_LD;
  assign is_st  = opc == OP_ST;
  assign is_opi = opc == OP_IMM;
  assign is_op  = opc == OP_REG;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0};

  logic [AW-1:0] widx;
  logic [31:0]   word, ld_val, wb_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  assign widx    = xw.alu[AW+1:2];
  assign word    = dmem[widx];
  assign ld_byte = 8'(word >> {xw.alu[1:0], 3'b000});
  assign ld_half = 16'(word >> {xw.alu[1], 4'b0000});

  // load lane extraction and extension
  always_comb begin
    unique case (xw.funct3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'b0, ld_byte};
      3'b101:  ld_val = {16'b0, ld_half};
      default: ld_val = word;
    endcase
  end

  // writeback select, also the forwarding source
  always_comb begin
    unique case (xw.wb_sel)
      WB_MEM:  wb_data = ld_val;
      WB_PC4:  wb_data = xw.pc4;
      default: wb_data = xw.alu;
    endcase
  end

  // rf_we is never set for x0, so x0 never forwards
  logic [31:0] rs1_val, rs2_val;
  assign rs1_val = (xw.rf_we && xw.rd == rs1) ? wb_data : rf[rs1];
  assign rs2_val = (xw.rf_we && xw.rd == rs2) ? wb_data : rf[rs2];

  logic [31:0] imm, op_a, op_b, alu;
  logic [2:0]  alu_f3;
  logic [4:0]  shamt;
  logic        alt;
  assign alu_f3 = (is_op || is_opi) ? f3 : 3'b000;
  assign alt    = inst[30] && (is_op || (is_opi && f3 == 3'b101));
  assign op_a   = is_lui ? 32'd0 : is_aui ? fd.pc : rs1_val;
  assign op_b   = is_op ? rs2_val : imm;
  assign shamt  = op_b[4:0];

  // immediate select
  always_comb begin
    unique case (1'b1)
      is_st:          imm = imm_s;
      is_lui, is_aui: imm = imm_u;
      default:        imm = imm_i;
    endcase
  end

  // ALU
  always_comb begin
    unique case (alu_f3)
      3'b000:  alu = alt ? op_a - op_b : op_a + op_b;
      3'b001:  alu = op_a << shamt;
      3'b010:  alu = {31'b0, $signed(op_a) < $signed(op_b)};
      3'b011:  alu = {31'b0, op_a < op_b};
      3'b100:  alu = op_a ^ op_b;
      3'b101: begin
        if (alt) alu = $signed(op_a) >>> shamt;
        else     alu = op_a >> shamt;
      end
      3'b110:  alu = op_a | op_b;
      default: alu = op_a & op_b;
    endcase
  end

  logic br_cond, taken;
  logic [31:0] target;

  // branch condition
  always_comb begin
    unique case (f3)
      3'b000:  br_cond = rs1_val == rs2_val;
      3'b001:  br_cond = rs1_val != rs2_val;
      3'b100:  br_cond = $signed(rs1_val) < $signed(rs2_val);
      3'b101:  br_cond = $signed(rs1_val) >= $signed(rs2_val);
      3'b110:  br_cond = rs1_val < rs2_val;
      3'b111:  br_cond = rs1_val >= rs2_val;
      default: br_cond = 1'b0;
    endcase
  end

  assign taken  = (is_br && br_cond) || is_jal || is_jlr;
  assign target = is_jlr ? {alu[31:1], 1'b0}
                : fd.pc + (is_jal ? imm_j : imm_b);

  // fetch: synchronous imem read, wrong-path slot squashed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      fd.pc   <= RESET_PC;
      fd.inst <= NOP;
    end else begin
      pc      <= taken ? target : pc + 32'd4;
      fd.pc   <= pc;
      fd.inst <= taken ? NOP : imem[pc[AW+1:2]];
    end
  end

  // execute -> memory/writeback register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xw <= '0;
    end else begin
      xw.rf_we  <= (is_lui || is_aui || is_jal || is_jlr ||
                    is_ld || is_opi || is_op) && rd != 5'd0;
      xw.rd     <= rd;
      xw.wb_sel <= is_ld ? WB_MEM
                 : (is_jal || is_jlr) ? WB_PC4 : WB_ALU;
      xw.store  <= is_st;
      xw.funct3 <= f3;
      xw.alu    <= alu;
      xw.sdata  <= rs2_val;
      xw.pc4    <= fd.pc + 32'd4;
    end
  end

  // register file write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          rf <= '0;
    else if (xw.rf_we) rf[xw.rd] <= wb_data;
  end

  logic [3:0]  be;
  logic [31:0] st_data;

  // store lane enables and replicated data
  always_comb begin
    unique case (xw.funct3[1:0])
      2'b00: begin
        be      = 4'b0001 << xw.alu[1:0];
        st_data = {4{xw.sdata[7:0]}};
      end
      2'b01: begin
        be      = xw.alu[1] ? 4'b1100 : 4'b0011;
        st_data = {2{xw.sdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        st_data = xw.sdata;
      end
    endcase
  end

  // stores land in dmem and keep imem coherent for loaded code
  always_ff @(posedge clk) begin
    if (xw.store) begin
      if (be[0]) begin
        dmem[widx][7:0] <= st_data[7:0];
        imem[widx][7:0] <= st_data[7:0];
      end
      if (be[1]) begin
        dmem[widx][15:8] <= st_data[15:8];
        imem[widx][15:8] <= st_data[15:8];
      end
      if (be[2]) begin
        dmem[widx][23:16] <= st_data[23:16];
        imem[widx][23:16] <= st_data[23:16];
      end
      if (be[3]) begin
        dmem[widx][31:24] <= st_data[31:24];
        imem[widx][31:24] <= st_data[31:24];
      end
    end
  end

  assign FPGA_SERIAL_TX = 1'b1;

  logic unused_bits;
  assign unused_bits = ^{FPGA_SERIAL_RX, xw.alu[31:AW+2],
                         CPU_CLOCK_FREQ != 0};
endmodule

// File: tb/tb_riscv151_core.sv
// tb_riscv151_core: program-level scoreboard bench for riscv151_core
// (register file and dmem peeked hierarchically).

module tb_riscv151_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic tx;

  riscv151_core dut (
    .clk(clk),
    .rst(rst),
    .FPGA_SERIAL_RX(rx),
    .FPGA_SERIAL_TX(tx)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] HALT = 32'h0000_006F;
  localparam logic [31:0] NOPI = 32'h0000_0013;

  typedef struct {
    string       name;
    bit          mem;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] e_i(int imm, int rs1, logic [2:0] f3,
                                      int rd, logic [6:0] opc);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), f3, 5'(rd), opc};
  endfunction

  function automatic logic [31:0] e_addi(int rd, int rs1, int imm);
    return e_i(imm, rs1, 3'b000, rd, 7'h13);
  endfunction

  function automatic logic [31:0] e_ld(logic [2:0] f3, int rd, int rs1,
                                       int imm);
    return e_i(imm, rs1, f3, rd, 7'h03);
  endfunction

  function automatic logic [31:0] e_r(logic [6:0] f7, logic [2:0] f3,
                                      int rd, int rs1, int rs2);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] e_st(logic [2:0] f3, int rs2, int rs1,
                                       int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), f3, v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] e_br(logic [2:0] f3, int rs1, int rs2,
                                       int imm);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), f3, v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] e_jal(int rd, int imm);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
  endfunction

  function automatic logic [31:0] e_lui(int rd, logic [31:0] val);
    logic [31:0] t;
    t = val + 32'h800;
    return {t[31:12], 5'(rd), 7'h37};
  endfunction

  function automatic void exp_reg(string n, int r, logic [31:0] v);
    exp_t e;
    e.name = n;
    e.mem = 1'b0;
    e.idx = r;
    e.exp = v;
    sb.push_back(e);
  endfunction

  function automatic void exp_mem(string n, int w, logic [31:0] v);
    exp_t e;
    e.name = n;
    e.mem = 1'b1;
    e.idx = w;
    e.exp = v;
    sb.push_back(e);
  endfunction

  task automatic boot();
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 64; i++)
      dut.imem[i] = (i < prog.size()) ? prog[i] : HALT;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic add_prog();
    prog.delete();
    prog.push_back(e_addi(1, 0, 100));
    prog.push_back(e_addi(2, 0, 200));
    prog.push_back(e_r(7'h00, 3'b000, 1, 1, 2));
    prog.push_back(e_addi(20, 0, 1));
  endtask

  task automatic test_reset();
    int nz;
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.rf[i] !== 32'd0) nz++;
    checks++;
    if (nz != 0) begin
      failures++;
      $display("FAIL reset_rf nonzero=%0d want 0", nz);
    end
    checks++;
    if (tx !== 1'b1) begin
      failures++;
      $display("FAIL reset_tx got %b want 1", tx);
    end
    checks++;
    if (dut.pc !== 32'd0) begin
      failures++;
      $display("FAIL reset_pc got %h want 0", dut.pc);
    end
    checks++;
    if (dut.fd.inst !== NOPI) begin
      failures++;
      $display("FAIL reset_ifid got %h want %h", dut.fd.inst, NOPI);
    end
  endtask

  task automatic test_add();
    exp_t e;
    logic [31:0] act;
    add_prog();
    exp_reg("add_x1", 1, 32'd300);
    exp_reg("add_x2", 2, 32'd200);
    boot();
    for (int c = 0; c < 300 && dut.rf[20] !== 32'd1; c++) @(negedge clk);
    checks++;
    if (dut.rf[20] !== 32'd1) begin
      failures++;
      $display("FAIL add_timeout x20=%h want 1", dut.rf[20]);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.mem ? dut.dmem[e.idx] : dut.rf[e.idx];
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s got %h want %h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic test_byte_loads();
    exp_t e;
    logic [31:0] act, w;
    logic [31:0] m[2];
    m[0] = 32'h4433_2211;
    m[1] = 32'h8877_6655;
    prog.delete();
    for (int k = 0; k < 8; k++) begin
      prog.push_back(e_ld(3'b100, 10 + k, 0, k));
      w = m[k / 4];
      exp_reg($sformatf("lbu_off%0d", k), 10 + k,
              (w >> (8 * (k % 4))) & 32'hFF);
    end
    prog.push_back(e_ld(3'b000, 18, 0, 7));
    prog.push_back(e_ld(3'b001, 19, 0, 6));
    prog.push_back(e_ld(3'b101, 21, 0, 2));
    prog.push_back(e_ld(3'b010, 22, 0, 4));
    prog.push_back(e_addi(20, 0, 3));
    exp_reg("lb_off7", 18, {{24{m[1][31]}}, m[1][31:24]});
    exp_reg("lh_off6", 19, {{16{m[1][31]}}, m[1][31:16]});
    exp_reg("lhu_off2", 21, {16'b0, m[0][31:16]});
    exp_reg("lw_w1", 22, m[1]);
    dut.dmem[0] = m[0];
    dut.dmem[1] = m[1];
    boot();
    for (int c = 0; c < 300 && dut.rf[20] !== 32'd3; c++) @(negedge clk);
    checks++;
    if (dut.rf[20] !== 32'd3) begin
      failures++;
      $display("FAIL loads_timeout x20=%h want 3", dut.rf[20]);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.mem ? dut.dmem[e.idx] : dut.rf[e.idx];
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s got %h want %h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic test_branch();
    exp_t e;
    logic [31:0] act;
    prog.delete();
    prog.push_back(e_addi(1, 0, 500));
    prog.push_back(e_addi(2, 0, 100));
    prog.push_back(e_br(3'b000, 1, 1, 8));
    prog.push_back(e_addi(1, 0, 1));
    prog.push_back(e_br(3'b001, 1, 1, 8));
    prog.push_back(e_addi(3, 0, 7));
    prog.push_back(e_addi(4, 0, -1));
    prog.push_back(e_br(3'b100, 4, 2, 8));
    prog.push_back(e_addi(5, 0, 9));
    prog.push_back(e_br(3'b110, 4, 2, 8));
    prog.push_back(e_addi(6, 0, 11));
    prog.push_back(e_br(3'b101, 2, 4, 8));
    prog.push_back(e_addi(7, 0, 13));
    prog.push_back(e_br(3'b111, 2, 4, 8));
    prog.push_back(e_addi(8, 0, 15));
    prog.push_back(e_addi(20, 0, 2));
    exp_reg("beq_x1", 1, 32'd500);
    exp_reg("beq_x2", 2, 32'd100);
    exp_reg("bne_nt_x3", 3, 32'd7);
    exp_reg("blt_skip_x5", 5, 32'd0);
    exp_reg("bltu_nt_x6", 6, 32'd11);
    exp_reg("bge_skip_x7", 7, 32'd0);
    exp_reg("bgeu_nt_x8", 8, 32'd15);
    boot();
    for (int c = 0; c < 300 && dut.rf[20] !== 32'd2; c++) @(negedge clk);
    checks++;
    if (dut.rf[20] !== 32'd2) begin
      failures++;
      $display("FAIL branch_timeout x20=%h want 2", dut.rf[20]);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.mem ? dut.dmem[e.idx] : dut.rf[e.idx];
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s got %h want %h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic test_forward();
    exp_t e;
    logic [31:0] act, m;
    m = $urandom;
    prog.delete();
    prog.push_back(e_addi(3, 0, 5));
    prog.push_back(e_r(7'h00, 3'b000, 4, 3, 3));
    prog.push_back(e_r(7'h00, 3'b000, 5, 4, 3));
    prog.push_back(e_ld(3'b010, 6, 0, 20));
    prog.push_back(e_r(7'h00, 3'b000, 7, 6, 6));
    prog.push_back(e_r(7'h20, 3'b000, 8, 7, 6));
    prog.push_back(e_addi(0, 0, 5));
    prog.push_back(e_r(7'h00, 3'b000, 9, 0, 0));
    prog.push_back(e_addi(20, 0, 4));
    exp_reg("fwd_x5", 5, 32'd15);
    exp_reg("ldfwd_x7", 7, m + m);
    exp_reg("ldfwd_x8", 8, m);
    exp_reg("x0_x9", 9, 32'd0);
    exp_reg("x0_zero", 0, 32'd0);
    dut.dmem[5] = m;
    boot();
    for (int c = 0; c < 300 && dut.rf[20] !== 32'd4; c++) @(negedge clk);
    checks++;
    if (dut.rf[20] !== 32'd4) begin
      failures++;
      $display("FAIL fwd_timeout x20=%h want 4", dut.rf[20]);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.mem ? dut.dmem[e.idx] : dut.rf[e.idx];
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s got %h want %h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic test_store_jal();
    exp_t e;
    logic [31:0] act;
    prog.delete();
    prog.push_back(e_addi(1, 0, 32'hAB));
    prog.push_back(e_st(3'b000, 1, 0, 161));
    prog.push_back(e_addi(2, 0, -2));
    prog.push_back(e_st(3'b001, 2, 0, 166));
    prog.push_back(e_jal(5, 8));
    prog.push_back(e_addi(6, 0, 1));
    prog.push_back(e_addi(7, 0, 41));
    prog.push_back(e_i(0, 7, 3'b000, 8, 7'h67));
    prog.push_back(e_addi(6, 0, 2));
    prog.push_back(e_addi(6, 0, 3));
    prog.push_back(e_addi(20, 0, 5));
    exp_mem("sb_off1", 40, 32'h0000_AB00);
    exp_mem("sh_hi", 41, 32'hFFFE_0000);
    exp_reg("jal_link", 5, 32'd20);
    exp_reg("jalr_link", 8, 32'd32);
    exp_reg("jump_skip", 6, 32'd0);
    dut.dmem[40] = 32'd0;
    dut.dmem[41] = 32'd0;
    boot();
    for (int c = 0; c < 300 && dut.rf[20] !== 32'd5; c++) @(negedge clk);
    checks++;
    if (dut.rf[20] !== 32'd5) begin
      failures++;
      $display("FAIL stjal_timeout x20=%h want 5", dut.rf[20]);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.mem ? dut.dmem[e.idx] : dut.rf[e.idx];
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s got %h want %h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic test_alu();
    exp_t e;
    logic [31:0] act, a, b, t;
    for (int it = 0; it < 2; it++) begin
      a = 32'h8000_0000 | $urandom;
      b = $urandom & 32'h7FFF_FFFF;
      prog.delete();
      prog.push_back(e_lui(1, a));
      prog.push_back(e_addi(1, 1, int'(a)));
      prog.push_back(e_lui(2, b));
      prog.push_back(e_addi(2, 2, int'(b)));
      prog.push_back(e_r(7'h00, 3'b000, 3, 1, 2));
      prog.push_back(e_r(7'h20, 3'b000, 4, 1, 2));
      prog.push_back(e_r(7'h00, 3'b001, 5, 1, 2));
      prog.push_back(e_r(7'h00, 3'b010, 6, 1, 2));
      prog.push_back(e_r(7'h00, 3'b011, 7, 1, 2));
      prog.push_back(e_r(7'h00, 3'b100, 8, 1, 2));
      prog.push_back(e_r(7'h00, 3'b101, 9, 1, 2));
      prog.push_back(e_r(7'h20, 3'b101, 10, 1, 2));
      prog.push_back(e_r(7'h00, 3'b110, 11, 1, 2));
      prog.push_back(e_r(7'h00, 3'b111, 12, 1, 2));
      prog.push_back(e_i(32'h407, 1, 3'b101, 13, 7'h13));
      prog.push_back(e_i(5, 1, 3'b010, 14, 7'h13));
      prog.push_back(e_i(-1, 2, 3'b011, 15, 7'h13));
      prog.push_back({20'h00001, 5'd16, 7'h17});
      prog.push_back(e_addi(20, 0, 6));
      exp_reg("li_a", 1, a);
      exp_reg("li_b", 2, b);
      exp_reg("add", 3, a + b);
      exp_reg("sub", 4, a - b);
      exp_reg("sll", 5, a << b[4:0]);
      exp_reg("slt", 6, 32'd1);
      exp_reg("sltu", 7, 32'd0);
      exp_reg("xor", 8, a ^ b);
      exp_reg("srl", 9, a >> b[4:0]);
      t = $signed(a) >>> b[4:0];
      exp_reg("sra", 10, t);
      exp_reg("or", 11, a | b);
      exp_reg("and", 12, a & b);
      t = $signed(a) >>> 7;
      exp_reg("srai", 13, t);
      exp_reg("slti", 14, 32'd1);
      exp_reg("sltiu", 15, 32'd1);
      exp_reg("auipc", 16, 32'h0000_1044);
      boot();
      for (int c = 0; c < 300 && dut.rf[20] !== 32'd6; c++) @(negedge clk);
      checks++;
      if (dut.rf[20] !== 32'd6) begin
        failures++;
        $display("FAIL alu_timeout x20=%h want 6", dut.rf[20]);
      end
      while (sb.size() > 0) begin
        e = sb.pop_front();
        act = e.mem ? dut.dmem[e.idx] : dut.rf[e.idx];
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL alu_%s got %h want %h a=%h b=%h",
                   e.name, act, e.exp, a, b);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    exp_t e;
    logic [31:0] act;
    int nz;
    add_prog();
    boot();
    for (int c = 0; c < 300 && dut.rf[20] !== 32'd1; c++) @(negedge clk);
    checks++;
    if (dut.rf[20] !== 32'd1) begin
      failures++;
      $display("FAIL midrun_pre_timeout x20=%h want 1", dut.rf[20]);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.rf[i] !== 32'd0) nz++;
    checks++;
    if (nz != 0) begin
      failures++;
      $display("FAIL midrun_async_rf nonzero=%0d want 0", nz);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || dut.pc !== 32'd0) begin
      failures++;
      $display("FAIL midrun_hold tx=%b pc=%h want 1/0", tx, dut.pc);
    end
    exp_reg("midrun_x1", 1, 32'd300);
    rst = 1'b1;
    for (int c = 0; c < 300 && dut.rf[20] !== 32'd1; c++) @(negedge clk);
    checks++;
    if (dut.rf[20] !== 32'd1) begin
      failures++;
      $display("FAIL midrun_timeout x20=%h want 1", dut.rf[20]);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.mem ? dut.dmem[e.idx] : dut.rf[e.idx];
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s got %h want %h", e.name, act, e.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_byte_loads();
    test_branch();
    test_forward();
    test_store_jal();
    test_alu();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
